// File: rtl/lut_cfg_loader.sv
// ---------------------------------------------------------------------------
// lut_cfg_loader
//
// Serial-to-parallel configuration loader for a bank of fracturable LUTs.
// A frame starts on `start` and carries NUM_LUTS words of CFG_W bits each.
// Each word arrives MSB-first over a valid/ready bit stream. Once a word is
// complete, it is presented on config_out for one COMMIT cycle. During that
// cycle, cen_out strobes the one target LUT that should capture it.
//
// Ports
//   cclk        in   configuration clock, all state on rising edge
//   rst_n       in   asynchronous active-low reset
//   start       in   begin a load frame (only looked at while idle)
//   abort       in   synchronous frame abort (priority over start/bits)
//   bit_in      in   serial config data
//   bit_valid   in   bit_in is valid
//   bit_ready   out  loader accepts a bit this cycle
//   config_out  out  [CFG_W-1:0] word being assembled / committed
//   cen_out     out  [NUM_LUTS-1:0] one-hot config enable, COMMIT only
//   busy        out  frame in progress
//   done        out  one-cycle pulse after the final COMMIT of a frame
// ---------------------------------------------------------------------------
module lut_cfg_loader #(
    parameter int INPUTS   = 4,
    parameter int MEM_SIZE = 2 ** INPUTS,
    parameter int CFG_W    = 2 * MEM_SIZE + 1,
    parameter int NUM_LUTS = 4
) (
    input  logic                cclk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic                bit_in,
    input  logic                bit_valid,
    output logic                bit_ready,
    output logic [CFG_W-1:0]    config_out,
    output logic [NUM_LUTS-1:0] cen_out,
    output logic                busy,
    output logic                done
);

    // Counter widths. They are clamped to at least one bit so that a
    // single-LUT build still elaborates.
    localparam int CNT_W = (CFG_W > 1) ? $clog2(CFG_W) : 1;
    localparam int IDX_W = (NUM_LUTS > 1) ? $clog2(NUM_LUTS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CFG_W - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_LUTS - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    logic [1:0]       state_q,   state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [IDX_W-1:0] lut_idx_q, lut_idx_d;
    logic [CFG_W-1:0] shreg_q,   shreg_d;
    logic             done_q,    done_d;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        lut_idx_d = lut_idx_q;
        shreg_d   = shreg_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Abort in IDLE has no effect other than masking start.
                if (start && !abort) begin
                    state_d   = ST_SHIFT;
                    bit_cnt_d = '0;
                    lut_idx_d = '0;
                end
            end

            ST_SHIFT: begin
                if (abort) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                    lut_idx_d = '0;
                    shreg_d   = '0;
                end else if (bit_valid) begin
                    // MSB-first: the first bit of a word ends up in the top bit.
                    shreg_d = {shreg_q[CFG_W-2:0], bit_in};
                    if (bit_cnt_q == CNT_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = ST_COMMIT;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end

            ST_COMMIT: begin
                // cen_out for this cycle is already on the wire.
                // An abort here only cancels the rest of the frame.
                if (abort) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                    lut_idx_d = '0;
                    shreg_d   = '0;
                end else if (lut_idx_q == IDX_LAST) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    lut_idx_d = lut_idx_q + 1'b1;
                    state_d   = ST_SHIFT;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge cclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            lut_idx_q <= '0;
            shreg_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            lut_idx_q <= lut_idx_d;
            shreg_q   <= shreg_d;
            done_q    <= done_d;
        end
    end

    // All outputs decode from registered state only. This lets the async
    // reset clear them immediately, without waiting for a clock edge.
    assign bit_ready  = (state_q == ST_SHIFT);
    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign config_out = shreg_q;

    generate
        for (genvar gi = 0; gi < NUM_LUTS; gi++) begin : g_cen
            assign cen_out[gi] = (state_q == ST_COMMIT) && (lut_idx_q == IDX_W'(gi));
        end
    endgenerate

endmodule

// File: tb/tb_lut_cfg_loader.sv
// ---------------------------------------------------------------------------
// tb_lut_cfg_loader
//
// Directed bench for lut_cfg_loader (INPUTS=4, CFG_W=33, NUM_LUTS=4).
// A frame-level reference model tracks how many bits of the current frame
// have been accepted. From that count alone it derives every output. The
// outputs are compared on every falling edge. Literal expectations pin the
// commit order, the config words, the commit timing and the reset behaviour.
// ---------------------------------------------------------------------------
module tb_lut_cfg_loader;

    localparam int CFG_W    = 33;
    localparam int NUM_LUTS = 4;

    logic                cclk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic                abort = 1'b0;
    logic                bit_in = 1'b0;
    logic                bit_valid = 1'b0;
    logic                bit_ready;
    logic [CFG_W-1:0]    config_out;
    logic [NUM_LUTS-1:0] cen_out;
    logic                busy;
    logic                done;

    lut_cfg_loader #(
        .INPUTS  (4),
        .NUM_LUTS(NUM_LUTS)
    ) dut (
        .cclk      (cclk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .bit_ready (bit_ready),
        .config_out(config_out),
        .cen_out   (cen_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 cclk = ~cclk;

    int cyc = 0;
    always @(posedge cclk) cyc <= cyc + 1;

    // ---------------- reference model (frame bit count based) -------------
    typedef struct packed {
        logic             busy;
        logic             commit;
        logic             done;
        logic [7:0]       bits;   // bits accepted so far in this frame
        logic [CFG_W-1:0] word;
    } mstate_t;

    mstate_t m = '0;

    function automatic mstate_t model_step(input mstate_t s, input logic st,
                                           input logic ab, input logic bv,
                                           input logic bi);
        mstate_t n;
        n      = s;
        n.done = 1'b0;
        if (!s.busy) begin
            if (st && !ab) begin
                n.busy   = 1'b1;
                n.bits   = 8'd0;
                n.commit = 1'b0;
            end
        end else if (ab) begin
            n.busy   = 1'b0;
            n.commit = 1'b0;
            n.bits   = 8'd0;
            n.word   = '0;
        end else if (s.commit) begin
            n.commit = 1'b0;
            if (int'(s.bits) == CFG_W * NUM_LUTS) begin
                n.busy = 1'b0;
                n.done = 1'b1;
            end
        end else if (bv) begin
            n.word = {s.word[CFG_W-2:0], bi};
            n.bits = s.bits + 8'd1;
            if ((int'(n.bits) % CFG_W) == 0) n.commit = 1'b1;
        end
        return n;
    endfunction

    always @(posedge cclk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else        m <= model_step(m, start, abort, bit_valid, bit_in);
    end

    // ---------------- bookkeeping ----------------------------------------
    int n_cmp  = 0;
    int n_fail = 0;

    logic [CFG_W-1:0] words [NUM_LUTS];

    logic [NUM_LUTS-1:0] ev_cen [$];
    logic [CFG_W-1:0]    ev_cfg [$];
    int                  ev_cyc [$];
    int                  done_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic compare_all();
        logic [NUM_LUTS-1:0] e_cen;
        e_cen = m.commit ? (NUM_LUTS'(1) << (int'(m.bits) / CFG_W - 1)) : '0;
        chk("bit_ready",  64'(bit_ready),  64'(m.busy && !m.commit));
        chk("busy",       64'(busy),       64'(m.busy));
        chk("done",       64'(done),       64'(m.done));
        chk("cen_out",    64'(cen_out),    64'(e_cen));
        chk("config_out", 64'(config_out), 64'(m.word));
        if (cen_out != '0) begin
            ev_cen.push_back(cen_out);
            ev_cfg.push_back(config_out);
            ev_cyc.push_back(cyc);
        end
        if (done) done_cnt++;
    endtask

    task automatic tick();
        @(posedge cclk);
        #2;
    endtask

    task automatic clear_events();
        ev_cen.delete();
        ev_cfg.delete();
        ev_cyc.delete();
        done_cnt = 0;
    endtask

    // Drive n bits of w MSB-first and hold each bit until it is accepted.
    // gap > 0 inserts idle cycles before every bit. When mid_start is set,
    // start is pulsed during a gap partway through the word.
    task automatic send_bits(input logic [CFG_W-1:0] w, input int n,
                             input int gap, input bit mid_start);
        logic r;
        int   tries;
        bit   acc;
        for (int i = 0; i < n; i++) begin
            if (gap > 0) begin
                bit_valid = 1'b0;
                if (mid_start && i == 5) start = 1'b1;
                repeat (gap) tick();
                start = 1'b0;
            end
            bit_valid = 1'b1;
            bit_in    = w[CFG_W-1-i];
            tries     = 0;
            acc       = 1'b0;
            while (!acc) begin
                r = bit_ready;
                tick();
                if (r) acc = 1'b1;
                else begin
                    tries++;
                    if (tries > 200) begin
                        chk("handshake_timeout", 64'(tries), 64'd0);
                        bit_valid = 1'b0;
                        return;
                    end
                end
            end
        end
        bit_valid = 1'b0;
    endtask

    task automatic run_frame(input int gap, input bit mid_start, output int t0);
        start = 1'b1;
        t0    = cyc;
        tick();
        start = 1'b0;
        for (int k = 0; k < NUM_LUTS; k++)
            send_bits(words[k], CFG_W, gap, mid_start && (k == 1));
        bit_valid = 1'b0;
        repeat (4) tick();
    endtask

    task automatic check_events(input int n, input int t0, input bit timing);
        chk("n_commits", 64'(ev_cen.size()), 64'(n));
        for (int k = 0; k < n && k < ev_cen.size(); k++) begin
            chk("commit_cen", 64'(ev_cen[k]), 64'd1 << k);
            chk("commit_cfg", 64'(ev_cfg[k]), 64'(words[k]));
            if (timing) chk("commit_cycle", 64'(ev_cyc[k] - t0), 64'(34 * (k + 1)));
        end
    endtask

    // ---------------- stimulus + per-cycle compare ----------------------
    initial begin
        int t0;
        words[0] = 33'h1FFFF0000;   // use_fracture=1, first=FFFF, second=0000
        words[1] = 33'h0A5A55A5A;
        words[2] = 33'h112345678;
        words[3] = 33'h0DEADBEEF;
        clear_events();

        fork
            begin : cmp_loop
                forever begin
                    @(negedge cclk);
                    compare_all();
                end
            end
        join_none

        // Reset state
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_busy",   64'(busy),       64'd0);
        chk("rst_ready",  64'(bit_ready),  64'd0);
        chk("rst_cen",    64'(cen_out),    64'd0);
        chk("rst_config", 64'(config_out), 64'd0);
        chk("rst_done",   64'(done),       64'd0);

        // Full frame, continuous valid
        clear_events();
        run_frame(0, 1'b0, t0);
        check_events(4, t0, 1'b1);
        chk("frame_done_pulses", 64'(done_cnt), 64'd1);
        $display("frame continuous: %0d commits, done pulses %0d", ev_cen.size(), done_cnt);

        // Gapped valid with a start pulse mid-frame
        clear_events();
        run_frame(2, 1'b1, t0);
        check_events(4, t0, 1'b0);
        chk("gap_done_pulses", 64'(done_cnt), 64'd1);
        $display("frame gapped: %0d commits, done pulses %0d", ev_cen.size(), done_cnt);

        // Abort after 20 bits of LUT 1
        clear_events();
        start = 1'b1;
        tick();
        start = 1'b0;
        send_bits(words[0], CFG_W, 0, 1'b0);
        send_bits(words[1], 20, 0, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        repeat (5) tick();
        check_events(1, 0, 1'b0);
        chk("abort_done",   64'(done_cnt),   64'd0);
        chk("abort_busy",   64'(busy),       64'd0);
        chk("abort_config", 64'(config_out), 64'd0);
        $display("abort: %0d commits, done pulses %0d", ev_cen.size(), done_cnt);

        // Fresh frame after abort reloads from LUT 0
        clear_events();
        run_frame(0, 1'b0, t0);
        check_events(4, t0, 1'b1);
        chk("reload_done_pulses", 64'(done_cnt), 64'd1);
        $display("reload: %0d commits, done pulses %0d", ev_cen.size(), done_cnt);

        // start and abort together in IDLE
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_busy", 64'(busy), 64'd0);
        tick();
        chk("start_abort_busy2", 64'(busy), 64'd0);
        $display("start+abort in idle: busy=%0d", busy);

        // Async reset during COMMIT of LUT 2
        clear_events();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 3; k++) send_bits(words[k], CFG_W, 0, 1'b0);
        chk("pre_rst_cen", 64'(cen_out), 64'b0100);
        rst_n = 1'b0;
        #1;
        chk("async_rst_cen",    64'(cen_out),    64'd0);
        chk("async_rst_config", 64'(config_out), 64'd0);
        chk("async_rst_ready",  64'(bit_ready),  64'd0);
        chk("async_rst_busy",   64'(busy),       64'd0);
        tick();
        tick();
        rst_n     = 1'b1;
        bit_valid = 1'b1;
        repeat (4) tick();
        chk("post_rst_ready", 64'(bit_ready), 64'd0);
        bit_valid = 1'b0;
        check_events(2, 0, 1'b0);
        $display("reset in commit: %0d commits before reset", ev_cen.size());

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/lut_cfg_loader.md
LUT_CFG_LOADER -- requirements
Module: lut_cfg_loader

Interface
REQ-001 SHALL have parameter INPUTS, default 4, the LUT address width per half of the target fracturable LUT.
REQ-002 SHALL have parameter MEM_SIZE, default 2**INPUTS, the entries per half-LUT.
REQ-003 SHALL have parameter CFG_W, default 2*MEM_SIZE+1, the per-LUT config word width: {use_fracture, first_lut, second_lut}.
REQ-004 SHALL have parameter NUM_LUTS, default 4, the number of target LUTs loaded per frame.
REQ-005 SHALL have one clock and an asynchronous, active-low reset: cclk  input  1  configuration clock, all state on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 start  input  1  begin a load frame; sampled only in IDLE.
REQ-008 abort  input  1  synchronous frame abort.
REQ-009 bit_in  input  1  serial config data.
REQ-010 bit_valid  input  1  bit_in is valid.
REQ-011 bit_ready  output  1  loader accepts a bit this cycle.
REQ-012 config_out  output  CFG_W  parallel config word to all targets.
REQ-013 cen_out  output  NUM_LUTS  one-hot config enable, bit i drives LUT i cen.
REQ-014 busy  output  1  frame in progress.
REQ-015 done  output  1  one-cycle frame-complete pulse.

Function
REQ-016 SHALL implement FSM states IDLE, SHIFT, COMMIT.
REQ-017 IDLE: start=1 and abort=0 -> SHIFT, bit_cnt=0, lut_idx=0; otherwise stay.
REQ-018 SHIFT: bit_ready=1; a bit is accepted only when bit_valid and bit_ready are both 1 on a rising cclk edge.
REQ-019 Accepted bits SHALL shift in MSB-first: shreg <= {shreg[CFG_W-2:0], bit_in}, so the first bit of each word lands in config_out[CFG_W-1] (use_fracture).
REQ-020 bit_cnt SHALL increment per accepted bit; acceptance at bit_cnt==CFG_W-1 -> COMMIT, bit_cnt=0.
REQ-021 bit_valid=0 in SHIFT SHALL stall with no state change and no timeout.
REQ-022 COMMIT SHALL last exactly one cycle with bit_ready=0 and cen_out = one-hot(lut_idx), decoded from the registered state.
REQ-023 config_out SHALL equal shreg and be stable throughout COMMIT.
REQ-024 cen_out SHALL be 0 in every state other than COMMIT.
REQ-025 Exit from COMMIT: if lut_idx==NUM_LUTS-1 -> IDLE and set done; else lut_idx+1 and -> SHIFT.
REQ-026 Latency: last bit of a word accepted at edge N -> cen_out asserted in cycle N+1; done high for exactly the one cycle after the final COMMIT.
REQ-027 busy SHALL be 1 in SHIFT and COMMIT, and 0 in IDLE.
REQ-028 start while busy SHALL be ignored.
REQ-029 abort=1 in SHIFT or COMMIT -> IDLE next edge with bit_cnt, lut_idx and shreg cleared and no done; a cen_out already asserted in that COMMIT cycle stands.
REQ-030 abort has priority over start and bit acceptance in the same cycle; abort in IDLE has no effect.
REQ-031 bit_cnt and lut_idx SHALL be sized $clog2 of their ranges and never wrap beyond CFG_W-1 and NUM_LUTS-1.

Reset
REQ-032 rst_n=0 SHALL immediately force IDLE and clear shreg, config_out, bit_cnt and lut_idx, with cen_out, done, busy and bit_ready all 0, including mid-frame.
REQ-033 After rst_n deasserts, the block SHALL require a new start before accepting bits.

Verification (INPUTS=4, CFG_W=33, NUM_LUTS=4)
REQ-034 Full frame, continuous valid, 132 bits, first word 1 + 0xFFFF + 0x0000 -> cen_out=0001 with config_out=0x1FFFF0000 at cycle 34 after start; cen_out 0010/0100/1000 follow, each 34 cycles apart; done pulses once.
REQ-035 Gapped bit_valid (1 of every 3 cycles) -> same config_out values and cen order as REQ-034; cen_out=0 during stalls.
REQ-036 abort asserted after 20 bits of LUT 1 -> IDLE, no further cen_out, done=0; a new start reloads from LUT 0.
REQ-037 start and abort in the same IDLE cycle -> remains IDLE with busy=0; start pulsed mid-frame -> no effect on bit_cnt or lut_idx.
REQ-038 rst_n pulled low during COMMIT of LUT 2 -> cen_out=0 and config_out=0 asynchronously, before the next edge; bit_ready=0 until the next start.
